// File: rtl/uart_pkg.sv
// Shared types and constants for the 12-byte command link.
//   uart_state_t : byte FSM states (IDLE, START, DATA, STOP)
//   UART_NUM_BYTES : bytes per command packet
//   cmd_buf_t : packed command buffer; byte 0 sits in bits [7:0]
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam int UART_NUM_BYTES = 12;

   typedef logic [UART_NUM_BYTES-1:0][7:0] cmd_buf_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Single 8N1 byte receiver: line synchroniser, byte FSM, tick/bit counters.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   data_in     : asynchronous UART line, idle high
//   byte_data   : received byte (valid while byte_ok is high)
//   byte_ok     : one-cycle pulse, stop bit sampled high
//   byte_err    : one-cycle pulse, stop bit sampled low
//   start_det   : one-cycle pulse, falling edge accepted in IDLE
//   active      : FSM is not in IDLE
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] byte_data,
   output logic       byte_ok,
   output logic       byte_err,
   output logic       start_det,
   output logic       active
);

   localparam int TICK_W = $clog2(CLKS_PER_BIT);
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(CLKS_PER_BIT - 1);

   logic              sync1_reg;
   logic              rx_s;
   logic              rx_d;
   logic              fall;
   uart_state_t       state_reg;
   uart_state_t       state_next;
   logic [TICK_W-1:0] tick_reg;
   logic [2:0]        bit_cnt_reg;
   logic [7:0]        shift_reg;
   logic              half_done;
   logic              full_done;

   // Synchroniser flops reset to the idle-high level so that leaving
   // reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= 1'b1;
         rx_s      <= 1'b1;
         rx_d      <= 1'b1;
      end else begin
         sync1_reg <= data_in;
         rx_s      <= sync1_reg;
         rx_d      <= rx_s;
      end
   end

   assign fall      = rx_d & ~rx_s;
   assign half_done = (tick_reg == HALF_LAST);
   assign full_done = (tick_reg == FULL_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:  if (fall) state_next = START;
         // A start bit that is high again at mid-bit is a glitch.
         START: if (half_done) state_next = rx_s ? IDLE : DATA;
         DATA:  if (full_done && bit_cnt_reg == 3'd7) state_next = STOP;
         STOP:  if (full_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      start_det = 1'b0;
      byte_ok   = 1'b0;
      byte_err  = 1'b0;
      active    = (state_reg != IDLE);
      byte_data = shift_reg;
      if (state_reg == IDLE && fall) start_det = 1'b1;
      if (state_reg == STOP && full_done) begin
         byte_ok  = rx_s;
         byte_err = ~rx_s;
      end
   end

   // Tick/bit counters and shift register. After the half-bit wait in
   // START the tick counter restarts, so every later sample lands mid-bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_reg    <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               tick_reg    <= '0;
               bit_cnt_reg <= '0;
            end
            START: tick_reg <= half_done ? '0 : tick_reg + TICK_W'(1);
            DATA: begin
               if (full_done) begin
                  tick_reg    <= '0;
                  shift_reg   <= {rx_s, shift_reg[7:1]};
                  bit_cnt_reg <= (bit_cnt_reg == 3'd7) ? 3'd0 : bit_cnt_reg + 3'd1;
               end else begin
                  tick_reg <= tick_reg + TICK_W'(1);
               end
            end
            STOP: tick_reg <= full_done ? '0 : tick_reg + TICK_W'(1);
            default: tick_reg <= '0;
         endcase
      end
   end

endmodule

// File: rtl/uart_receive.sv
// Command packet receiver: assembles NUM_BYTES consecutive UART bytes into
// a command buffer, aborting on a bad stop bit or an inter-byte timeout.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   data_in    : asynchronous UART line, idle high
//   cmd_buf    : last complete packet, byte 0 = first byte received
//   cmd_valid  : one-cycle pulse when cmd_buf has just been updated
//   frame_err  : one-cycle pulse on bad stop bit or timeout
//   busy       : byte in progress or partial packet held
// NUM_BYTES must be at least 2.
module uart_receive
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int NUM_BYTES    = UART_NUM_BYTES,
   parameter int TIMEOUT_BITS = 24
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      data_in,
   output logic [NUM_BYTES-1:0][7:0] cmd_buf,
   output logic                      cmd_valid,
   output logic                      frame_err,
   output logic                      busy
);

   localparam int IDX_W = $clog2(NUM_BYTES);
   localparam int TO_W  = $clog2(TIMEOUT_BITS*CLKS_PER_BIT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_BITS*CLKS_PER_BIT - 1);

   logic [7:0]                byte_data;
   logic                      byte_ok;
   logic                      byte_err;
   logic                      start_det;
   logic                      active;
   logic [NUM_BYTES-1:0][7:0] work_buf_reg;
   logic [NUM_BYTES-1:0][7:0] packet;
   logic [IDX_W-1:0]          byte_idx_reg;
   logic [TO_W-1:0]           to_cnt_reg;

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx_byte (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .byte_data(byte_data),
      .byte_ok  (byte_ok),
      .byte_err (byte_err),
      .start_det(start_det),
      .active   (active)
   );

   // Working buffer with the incoming byte merged in at byte_idx; on the
   // final byte this is the complete packet copied to cmd_buf.
   for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_merge
      assign packet[gi] = (byte_idx_reg == IDX_W'(gi)) ? byte_data : work_buf_reg[gi];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         work_buf_reg <= '0;
         byte_idx_reg <= '0;
         to_cnt_reg   <= '0;
         cmd_buf      <= '0;
         cmd_valid    <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;

         if (byte_ok) begin
            work_buf_reg <= packet;
            if (byte_idx_reg == LAST_IDX) begin
               cmd_buf      <= packet;
               cmd_valid    <= 1'b1;
               byte_idx_reg <= '0;
            end else begin
               byte_idx_reg <= byte_idx_reg + IDX_W'(1);
            end
         end else if (byte_err) begin
            frame_err    <= 1'b1;
            byte_idx_reg <= '0;
         end

         // Inter-byte timeout only runs while a partial packet waits in
         // IDLE. byte_ok/byte_err only occur while active, so this never
         // collides with the stop-bit handling above. A start edge in the
         // expiry cycle wins.
         if (start_det || active || byte_idx_reg == '0) begin
            to_cnt_reg <= '0;
         end else if (to_cnt_reg == TO_LAST) begin
            to_cnt_reg   <= '0;
            frame_err    <= 1'b1;
            byte_idx_reg <= '0;
         end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
         end
      end
   end

   assign busy = active | (byte_idx_reg != '0);

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive: directed scenarios followed by
// randomized frames, gaps, glitches, bad stop bits and resets, all checked
// every cycle against a transaction-level model of the packet receiver.
module tb_uart_receive;

   localparam int CPB      = 16;
   localparam int NB       = 12;
   localparam int TO_BITS  = 24;
   // Start edge driven after edge T -> stop-bit sample result visible at T+STOP_LAT
   localparam int STOP_LAT = 3 + CPB/2 + 9*CPB;
   localparam int TO_CYC   = TO_BITS*CPB;
   localparam int EV_VALID = 0;
   localparam int EV_ERR   = 1;
   localparam int EV_RST   = 2;

   typedef struct {
      int                  at;
      int                  kind;
      logic [NB-1:0][7:0]  data;
   } ev_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               data_in = 1'b1;
   logic [NB-1:0][7:0] cmd_buf;
   logic               cmd_valid;
   logic               frame_err;
   logic               busy;

   uart_receive #(
      .CLKS_PER_BIT(CPB),
      .NUM_BYTES   (NB),
      .TIMEOUT_BITS(TO_BITS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .cmd_buf  (cmd_buf),
      .cmd_valid(cmd_valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Model state (advanced by the driver as each transaction is scheduled)
   ev_t                evq[$];
   int                 m_idx = 0;
   logic [NB-1:0][7:0] m_work = '0;
   int                 last_stop = 0;

   int                 vectors = 0;
   int                 miscompares = 0;
   int                 valid_cnt = 0;
   int                 err_cnt = 0;
   int                 last_err_cyc = -1;
   bit                 chk_en = 1'b0;
   logic [NB-1:0][7:0] exp_buf = '0;
   ev_t                cur_ev;
   bit                 exp_v;
   bit                 exp_e;

   task automatic check(input string name, input logic [NB*8-1:0] act, input logic [NB*8-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic push_ev(input int at, input int kind, input logic [NB-1:0][7:0] d);
      ev_t e;
      e.at = at; e.kind = kind; e.data = d;
      evq.push_back(e);
   endtask

   // Per-cycle comparison of all pulse and buffer outputs
   always @(negedge clk) begin
      if (chk_en) begin
         exp_v = 1'b0;
         exp_e = 1'b0;
         while (evq.size() > 0 && evq[0].at < cyc) begin
            cur_ev = evq.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_event kind %0d due cycle %0d, now %0d", cur_ev.kind, cur_ev.at, cyc);
         end
         if (evq.size() > 0 && evq[0].at == cyc) begin
            cur_ev = evq.pop_front();
            case (cur_ev.kind)
               EV_VALID: begin exp_v = 1'b1; exp_buf = cur_ev.data; end
               EV_ERR:   exp_e = 1'b1;
               default:  exp_buf = '0;
            endcase
         end
         check("cmd_valid", cmd_valid, exp_v);
         check("frame_err", frame_err, exp_e);
         check("cmd_buf", cmd_buf, exp_buf);
         if (cmd_valid) valid_cnt++;
         if (frame_err) begin err_cnt++; last_err_cyc = cyc; end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Idle for g cycles; a pending partial packet times out unless the next
   // start edge (detected 3 cycles after it is driven) arrives in time.
   task automatic resolve_gap(input int g);
      int t_next;
      t_next = cyc + g;
      if (m_idx != 0 && t_next + 3 > last_stop + TO_CYC) begin
         push_ev(last_stop + TO_CYC, EV_ERR, '0);
         m_idx = 0;
      end
      step(g);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      data_in = 1'b1;
      push_ev(cyc + 1, EV_RST, '0);
      m_idx  = 0;
      m_work = '0;
      step(1);
      reset = 1'b0;
   endtask

   // abort_at >= 0: reset in the middle of that data bit instead of finishing
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int abort_at = -1);
      int t0;
      t0 = cyc;
      if (abort_at < 0) begin
         if (!stop_ok) begin
            push_ev(t0 + STOP_LAT, EV_ERR, '0);
            m_idx = 0;
         end else begin
            m_work[m_idx] = d;
            if (m_idx == NB - 1) begin
               push_ev(t0 + STOP_LAT, EV_VALID, m_work);
               m_idx = 0;
            end else begin
               m_idx++;
            end
         end
      end
      data_in = 1'b0;
      step(CPB);
      for (int i = 0; i < 8; i++) begin
         if (abort_at == i) begin
            step(5);
            do_reset();
            step(20);
            return;
         end
         data_in = d[i];
         step(CPB);
      end
      data_in = stop_ok;
      step(CPB);
      data_in = 1'b1;
      last_stop = t0 + STOP_LAT;
   endtask

   task automatic glitch();
      data_in = 1'b0;
      step(4);
      data_in = 1'b1;
      step(30);
   endtask

   task automatic send_packet_rand();
      for (int i = 0; i < NB; i++) send_frame(8'($urandom), 1'b1);
   endtask

   logic [NB-1:0][7:0] lit;
   int                 saved;
   bit                 need_idle;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      step(2);
      chk_en = 1'b1;
      step(1);
      reset = 1'b0;
      // Reset state
      check("reset_cmd_valid", cmd_valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_cmd_buf", cmd_buf, '0);
      resolve_gap(10);

      // Packet of 0x01..0x0C, one stop bit each
      for (int i = 0; i < NB; i++) send_frame(8'(i + 1), 1'b1);
      resolve_gap(10);
      lit = 96'h0C0B0A09_08070605_04030201;
      check("pkt1_literal", cmd_buf, lit);
      check("pkt1_valid_cnt", 32'(valid_cnt), 32'd1);
      check("pkt1_err_cnt", 32'(err_cnt), 32'd0);

      // Short low glitch on an idle line
      resolve_gap(20);
      glitch();
      check("glitch_busy", busy, 1'b0);
      check("glitch_valid_cnt", 32'(valid_cnt), 32'd1);
      check("glitch_err_cnt", 32'(err_cnt), 32'd0);

      // Bad stop bit on the fifth byte, then a clean 0xA5 packet
      for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
      send_frame(8'h3C, 1'b0);
      resolve_gap(2*CPB);
      check("badstop_err_cnt", 32'(err_cnt), 32'd1);
      check("badstop_buf_kept", cmd_buf, lit);
      for (int i = 0; i < NB; i++) send_frame(8'hA5, 1'b1);
      resolve_gap(10);
      lit = {NB{8'hA5}};
      check("a5_literal", cmd_buf, lit);
      check("a5_valid_cnt", 32'(valid_cnt), 32'd2);

      // Three bytes, then 25 idle bit periods -> timeout 24 bit periods after stop sample
      for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
      saved = last_stop;
      step(100);
      check("partial_busy", busy, 1'b1);
      resolve_gap(25*CPB - 100);
      check("timeout_err_cnt", 32'(err_cnt), 32'd2);
      check("timeout_delay", 32'(last_err_cyc - saved), 32'd384);
      check("timeout_busy", busy, 1'b0);
      send_packet_rand();
      resolve_gap(10);

      // Start edge landing exactly on the expiry cycle wins; one cycle later loses
      for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
      resolve_gap(376);
      for (int i = 0; i < 9; i++) send_frame(8'($urandom), 1'b1);
      for (int i = 0; i < 2; i++) send_frame(8'($urandom), 1'b1);
      resolve_gap(377);
      send_packet_rand();
      resolve_gap(10);
      check("tie_err_cnt", 32'(err_cnt), 32'd3);

      // Reset in the middle of byte 7's data bits
      for (int i = 0; i < 6; i++) send_frame(8'($urandom), 1'b1);
      send_frame(8'h77, 1'b1, 3);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_buf", cmd_buf, '0);
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      send_packet_rand();
      resolve_gap(10);

      // Two back-to-back packets alternating 0x00/0xFF
      for (int i = 0; i < 2*NB; i++) send_frame((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1);
      resolve_gap(10);
      lit = {6{16'hFF00}};
      check("alt_literal", cmd_buf, lit);

      // Randomized traffic
      need_idle = 1'b0;
      for (int n = 0; n < 90; n++) begin
         int r;
         int g;
         r = int'($urandom_range(0, 99));
         if (need_idle)                          g = int'($urandom_range(CPB, 3*CPB));
         else if ($urandom_range(0, 9) == 0)     g = int'($urandom_range(370, 385));
         else                                    g = int'($urandom_range(0, 40));
         resolve_gap(g);
         need_idle = 1'b0;
         if (r < 5 && m_idx == 0) begin
            glitch();
         end else if (r < 8) begin
            send_frame(8'($urandom), 1'b1, int'($urandom_range(0, 7)));
         end else if (r < 13) begin
            send_frame(8'($urandom), 1'b0);
            need_idle = 1'b1;
         end else begin
            send_frame(8'($urandom), 1'b1);
         end
      end

      resolve_gap(TO_CYC + 200);
      check("events_drained", 32'(evq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_receive.md
# uart_receive

Serial-to-parallel command receiver: the far end of the 12-byte command link driven by the FPGA's UART transmitter. Synchronises the incoming line, detects and samples 8N1 frames (start, 8 data bits LSB-first, ≥1 stop bit) with a mid-bit oversampling counter, and assembles 12 consecutive bytes into a command buffer. The completed buffer is presented with a one-cycle valid pulse. Framing errors and inter-byte timeouts abort the packet.

## Interface
- CLKS_PER_BIT, 16, clk cycles per bit period; even, ≥ 4
- NUM_BYTES, 12, bytes per command packet (six 16-bit words)
- TIMEOUT_BITS, 24, maximum idle gap between bytes of one packet, in bit periods
- clk  input  1  single clock for all logic
- reset  input  1  synchronous, active-high reset
- data_in  input  1  asynchronous UART line, idle high
- cmd_buf  output  [NUM_BYTES-1:0][7:0]  last complete packet; byte 0 is the first byte received
- cmd_valid  output  1  one-cycle pulse when cmd_buf has just been updated
- frame_err  output  1  one-cycle pulse on a bad stop bit or timeout; the packet is discarded
- busy  output  1  high from start-bit detect until the packet completes or aborts

## Operation
- data_in passes through a 2-flop synchroniser, then a third flop for edge detection. All decisions use the synchronised value rx_s.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on rx_s loads the tick counter and goes to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If rx_s=0, clear the tick counter and go to DATA. If rx_s=1, treat it as a glitch and return to IDLE; nothing is stored and there is no error.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit and shift right into the shift register (bit 0 first). After the 8th sample, go to STOP.
  - STOP: sample once at mid-bit, then return to IDLE on the same cycle.
    - rx_s=1: write the shift register into work_buf[byte_idx]. If byte_idx==NUM_BYTES-1, copy work_buf (including this byte) to cmd_buf, pulse cmd_valid and clear byte_idx. Otherwise increment byte_idx.
    - rx_s=0: pulse frame_err, clear byte_idx; cmd_buf is unchanged.
- After the stop sample, a new start edge is accepted immediately. One stop bit is sufficient; extra idle bits are tolerated.
- Timeout counter:
  - Runs only in IDLE while byte_idx≠0.
  - Expires at TIMEOUT_BITS·CLKS_PER_BIT cycles: pulse frame_err, clear byte_idx.
  - Cleared on each start-bit detect.
- busy = (state≠IDLE) or (byte_idx≠0).
- cmd_buf is only written on a complete, error-free packet, so it holds stable between cmd_valid pulses.
- Widths:
  - tick counter: $clog2(CLKS_PER_BIT) bits
  - bit counter: 3 bits
  - byte_idx: $clog2(NUM_BYTES) bits
  - timeout counter: $clog2(TIMEOUT_BITS·CLKS_PER_BIT+1) bits
  - No counter wraps in normal operation. byte_idx never exceeds NUM_BYTES-1.

## Timing
- Reset values: cmd_buf=0, cmd_valid=0, frame_err=0, busy=0. FSM=IDLE, byte_idx=0, all counters 0.
- Reset mid-frame or mid-packet discards partial data with no error pulse. Reset has priority over every other event in the same cycle.
- Synchroniser plus edge-detect latency: 3 cycles from a data_in transition to the IDLE→START decision.
- cmd_valid and the cmd_buf update occur in the cycle after the stop-bit sample of the final byte. A frame with its start edge at cycle T gives about T + 3 + 9.5·CLKS_PER_BIT.
- Simultaneous events:
  - Timeout expiry and a start edge in the same cycle: the start edge wins and the timeout is cleared.
  - Final-byte completion and reset in the same cycle: reset wins, with no cmd_valid.
- cmd_valid and frame_err are never high in the same cycle.

## Structure
- Package uart_pkg holds:
  - the typedef uart_state_t enum {IDLE, START, DATA, STOP}
  - the constant UART_NUM_BYTES=12
  - the typedef cmd_buf_t = logic [UART_NUM_BYTES-1:0][7:0], shared with the transmitter
- One sub-module is natural: uart_rx_byte.
  - Contains the synchroniser, byte FSM and tick/bit counters.
  - Outputs: byte_data[7:0], byte_ok pulse, byte_err pulse, start_det pulse.
  - uart_receive holds work_buf, byte_idx, the timeout counter and cmd_buf.

## Test plan
- 12 frames of bytes 0x01…0x0C, one stop bit each, CLKS_PER_BIT=16 -> exactly one cmd_valid; cmd_buf[0]=0x01 … cmd_buf[11]=0x0C; frame_err never asserted.
- A 4-cycle low glitch on an idle line -> FSM returns to IDLE; no cmd_valid, no frame_err; byte_idx stays 0.
- Stop bit of byte 5 driven 0 -> one frame_err pulse; cmd_buf unchanged. A following clean 12-byte packet of 0xA5 -> cmd_valid with all bytes 0xA5.
- 3 good bytes, then the line idles for 25 bit periods -> frame_err at 24 bit periods after the last stop sample. The next 12 bytes load cmd_buf from index 0.
- Reset asserted for 1 cycle mid-DATA of byte 7 -> all outputs 0. A subsequent full packet is received correctly.
- Two packets back-to-back with no idle between frames, and the data bit pattern 0x00/0xFF alternating -> two cmd_valid pulses, each with the correct contents.
